aes_cipher: RTL and testbench



---
 rtl/aes_cipher_pkg.sv | 29 ++
 rtl/aes_sbox.sv | 56 +++++
 rtl/aes_cipher.sv | 72 +++++++
 tb/tb_aes_cipher.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/aes_cipher_pkg.sv
// Shared types and constants for the byte-serial AES-S-box counter-mode cipher.
// Holds the FIPS-197 forward S-box table and the GF(2^8) constants used by the computed S-box.
package aes_cipher_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t       AFFINE_CONST = 8'h63;
    localparam logic [8:0]  GF_POLY      = 9'h11B;

    localparam byte_t SBOX_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box. Table lookup by default; define
// AES_CIPHER_COMPUTED_SBOX_EN to build it from GF(2^8) inversion plus the affine transform.
module aes_sbox
    import aes_cipher_pkg::*;
(
    input  logic [7:0] sbox_in,
    output logic [7:0] sbox_out
);

`ifdef AES_CIPHER_COMPUTED_SBOX_EN
    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            if (aa[7]) begin
                aa = {aa[6:0], 1'b0} ^ GF_POLY[7:0];
            end else begin
                aa = {aa[6:0], 1'b0};
            end
        end
        return p;
    endfunction

    // x^254 is the inverse in GF(2^8) and conveniently maps 0 to 0.
    function automatic byte_t gf_inv(input byte_t x);
        byte_t sq;
        byte_t acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic byte_t affine(input byte_t b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ AFFINE_CONST;
    endfunction

    always_comb begin
        sbox_out = affine(gf_inv(sbox_in));
    end
`else
    always_comb begin
        sbox_out = SBOX_TABLE[sbox_in];
    end
`endif

endmodule

// File: rtl/aes_cipher.sv
// Byte-serial counter-mode cipher: out = in ^ SBOX(ctr ^ key), registered one cycle later.
// S-box build selected by AES_CIPHER_COMPUTED_SBOX_EN (see aes_sbox).
module aes_cipher
    import aes_cipher_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_in,
    input  logic       new_message,
    input  logic [7:0] key,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       valid_out
);

    // valid_in qualifies data_in for one cycle with no ready: every valid byte is
    // consumed, and valid_out/data_out follow exactly one cycle later.
    byte_t key_q, key_d;
    byte_t ctr_q, ctr_d;
    byte_t data_out_q, data_out_d;
    logic  valid_out_q, valid_out_d;

    byte_t key_eff;
    byte_t ctr_eff;
    byte_t sbox_in;
    byte_t ks;

    // A byte arriving with new_message uses the fresh key and counter 0.
    always_comb begin
        key_eff = new_message ? key : key_q;
        ctr_eff = new_message ? 8'h00 : ctr_q;
        sbox_in = ctr_eff ^ key_eff;
    end

    aes_sbox u_sbox (
        .sbox_in  (sbox_in),
        .sbox_out (ks)
    );

    always_comb begin
        key_d       = key_q;
        ctr_d       = ctr_q;
        data_out_d  = data_out_q;
        valid_out_d = valid_in;
        if (new_message) begin
            key_d = key;
            ctr_d = 8'h00;
        end
        if (valid_in) begin
            data_out_d = data_in ^ ks;
            ctr_d      = ctr_eff + 8'h01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_q       <= 8'h00;
            ctr_q       <= 8'h00;
            data_out_q  <= 8'h00;
            valid_out_q <= 1'b0;
        end else begin
            key_q       <= key_d;
            ctr_q       <= ctr_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;

endmodule

// File: tb/tb_aes_cipher.sv
// Directed bench for aes_cipher: vector table, counter wrap, reset mid-stream,
// and an exhaustive aes_sbox sweep against an independently derived reference.
module tb_aes_cipher;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_in;
    logic       new_message;
    logic [7:0] key;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       valid_out;

    logic [7:0] sbox_in_tb;
    logic [7:0] sbox_out_tb;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_sbox [256];
    logic [7:0] exp_q [$];

    typedef struct {
        logic       v;
        logic       nm;
        logic [7:0] k;
        logic [7:0] d;
        logic       ev;
        logic [7:0] ed;
    } vec_t;

    vec_t vecs [17];

    always #5 clk = ~clk;

    aes_cipher dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .new_message (new_message),
        .key         (key),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out)
    );

    aes_sbox u_sbox_chk (
        .sbox_in  (sbox_in_tb),
        .sbox_out (sbox_out_tb)
    );

    // Carry-less product then polynomial reduction from the top bit down.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        logic [14:0] poly;
        p = 15'd0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (15'(a) << i);
        end
        for (int j = 14; j >= 8; j--) begin
            poly = 15'h11B << (j - 8);
            if (p[j]) p = p ^ poly;
        end
        return p[7:0];
    endfunction

    function automatic logic [7:0] ref_affine(input logic [7:0] b);
        logic [7:0] c;
        logic [7:0] r;
        c = 8'h63;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8]
                 ^ b[(i + 7) % 8] ^ c[i];
        end
        return r;
    endfunction

    task automatic build_ref();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            ref_sbox[x] = ref_affine(inv);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one cycle from a negedge; returns at the next negedge with outputs settled.
    task automatic cycle(input logic r, input logic v, input logic nm,
                         input logic [7:0] k, input logic [7:0] d);
        reset       = r;
        valid_in    = v;
        new_message = nm;
        key         = k;
        data_in     = d;
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        valid_in    = 1'b0;
        new_message = 1'b0;
        key         = 8'h00;
        data_in     = 8'h00;
        sbox_in_tb  = 8'h00;
        build_ref();

        //           v     nm    key    data   ev    ed
        vecs[0]  = '{1'b0, 1'b1, 8'h11, 8'h00, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h82};
        vecs[2]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'hCA};
        vecs[3]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h7D};
        vecs[4]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'hC9};
        vecs[5]  = '{1'b0, 1'b1, 8'h11, 8'h00, 1'b0, 8'hC9};
        vecs[6]  = '{1'b1, 1'b0, 8'h00, 8'h82, 1'b1, 8'h00};
        vecs[7]  = '{1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 8'h63};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h7C};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 8'hAA, 1'b0, 8'h7C};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 8'hAA, 1'b0, 8'h7C};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 8'hAA, 1'b0, 8'h7C};
        vecs[12] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h77};
        vecs[13] = '{1'b1, 1'b0, 8'h00, 8'hFF, 1'b1, 8'h84};
        vecs[14] = '{1'b1, 1'b1, 8'h5A, 8'h3C, 1'b1, 8'h82};
        vecs[15] = '{1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h82};
        vecs[16] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 8'h39};

        @(negedge clk);
        cycle(1'b1, 1'b1, 1'b1, 8'h11, 8'h55);
        check8("reset_valid_out", 8'(valid_out), 8'h00);
        check8("reset_data_out", data_out, 8'h00);

        for (int i = 0; i < 17; i++) begin
            cycle(1'b0, vecs[i].v, vecs[i].nm, vecs[i].k, vecs[i].d);
            check8($sformatf("vec%0d_valid", i), 8'(valid_out), 8'(vecs[i].ev));
            check8($sformatf("vec%0d_data", i), data_out, vecs[i].ed);
        end

        // 257 bytes under key 0: keystream is S(ctr), last byte sees ctr wrapped to 0.
        for (int i = 0; i < 257; i++) begin
            exp_q.push_back(ref_sbox[i % 256]);
            cycle(1'b0, 1'b1, (i == 0), 8'h00, 8'h00);
            check8($sformatf("wrap%0d_valid", i), 8'(valid_out), 8'h01);
            check8($sformatf("wrap%0d_data", i), data_out, exp_q.pop_front());
        end
        check8("wrap_last_byte", data_out, 8'h63);

        // Reset the cycle after a valid byte drops the output and all state.
        cycle(1'b0, 1'b1, 1'b1, 8'h11, 8'h00);
        check8("pre_reset_data", data_out, 8'h82);
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
        check8("mid_reset_valid", 8'(valid_out), 8'h00);
        check8("mid_reset_data", data_out, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 8'h11, 8'h00);
        check8("post_reset_valid", 8'(valid_out), 8'h01);
        check8("post_reset_data", data_out, 8'h82);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        check8("idle_valid", 8'(valid_out), 8'h00);

        for (int i = 0; i < 256; i++) begin
            sbox_in_tb = 8'(i);
            #1;
            check8($sformatf("sbox_%02h", i), sbox_out_tb, ref_sbox[i]);
        end
        sbox_in_tb = 8'h00;
        #1;
        check8("sbox_00_const", sbox_out_tb, 8'h63);
        sbox_in_tb = 8'hFF;
        #1;
        check8("sbox_ff_const", sbox_out_tb, 8'h16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
